// File: rtl/four_inputs_pkg.sv
// Shared definitions for the four_inputs_sweep self-check stage.
// Contents:
//   state_t     - sweep controller states (IDLE, RUN, DONE)
//   VEC_W       - width of the gate input vector {a,b,c,d}
//   NUM_VEC     - number of input combinations walked per sweep
//   GATE_EXPECT - truth table of four_inputs_gate, bit index = {a,b,c,d}
package four_inputs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  localparam logic [NUM_VEC-1:0] GATE_EXPECT = 16'h8BD7;

endpackage

// File: rtl/four_inputs_sweep.sv
// Stimulus/capture stage for four_inputs_gate. On start it walks {a,b,c,d}
// through 0..15, holds each vector SETTLE cycles, samples the gate output
// at the end of the hold, and compares the observed table against EXPECT.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// RUN   | driving vectors and sampling out
// DONE  | one-cycle done pulse, results valid
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   sweep request, sampled in IDLE only
//   out          in   gate output under test
//   a,b,c,d      out  gate inputs, {a,b,c,d} = current vector
//   busy         out  sweep in progress
//   done         out  one-cycle pulse at sweep end
//   result       out  observed truth table
//   pass         out  result == EXPECT
//   mismatch_cnt out  number of differing entries (0..16)
//   first_fail   out  lowest failing vector, 0 when passing
module four_inputs_sweep
  import four_inputs_pkg::*;
#(
  parameter int unsigned        SETTLE = 2,
  parameter logic [NUM_VEC-1:0] EXPECT = GATE_EXPECT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               out,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] result,
  output logic               pass,
  output logic [4:0]         mismatch_cnt,
  output logic [VEC_W-1:0]   first_fail
);

  localparam logic [VEC_W-1:0] SETTLE_LAST = VEC_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] vector;
  logic [VEC_W-1:0] settle_cnt;
  logic             sample;
  logic             last_vec;

  assign sample   = (state == RUN) && (settle_cnt == SETTLE_LAST);
  assign last_vec = (vector == VEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (sample && last_vec) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vector       <= '0;
      settle_cnt   <= '0;
      result       <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vector       <= '0;
            settle_cnt   <= '0;
            result       <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            settle_cnt     <= '0;
            result[vector] <= out;
            if (out != EXPECT[vector]) begin
              mismatch_cnt <= mismatch_cnt + 5'd1;
              // Count still zero means this is the first miss of the sweep.
              if (mismatch_cnt == 5'd0) first_fail <= vector;
            end
            if (last_vec) begin
              // Final entry is still in flight, so compare with it spliced in;
              // this makes pass valid in the same cycle as done.
              pass   <= ({out, result[NUM_VEC-2:0]} == EXPECT);
              vector <= '0;
            end else begin
              vector <= vector + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {a, b, c, d} = vector;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_four_inputs_sweep.sv
// Bench for four_inputs_sweep: three instances with SETTLE = 2, 1, 3, each
// driven by a bench-side table that plays the role of the gate.
module tb_four_inputs_sweep;
  import four_inputs_pkg::*;

  logic        clk;
  logic        rst;
  logic        start  [3];
  logic        out_s  [3];
  logic        a [3], b [3], c [3], d [3];
  logic        busy   [3];
  logic        done   [3];
  logic [15:0] result [3];
  logic        pass   [3];
  logic [4:0]  mm     [3];
  logic [3:0]  ff     [3];
  logic [15:0] tbl    [3];

  int settle_of [3] = '{2, 1, 3};
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_s[0] = tbl[0][{a[0], b[0], c[0], d[0]}];
  assign out_s[1] = tbl[1][{a[1], b[1], c[1], d[1]}];
  assign out_s[2] = tbl[2][{a[2], b[2], c[2], d[2]}];

  four_inputs_sweep #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .out(out_s[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .busy(busy[0]), .done(done[0]),
    .result(result[0]), .pass(pass[0]), .mismatch_cnt(mm[0]), .first_fail(ff[0])
  );

  four_inputs_sweep #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .out(out_s[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .busy(busy[1]), .done(done[1]),
    .result(result[1]), .pass(pass[1]), .mismatch_cnt(mm[1]), .first_fail(ff[1])
  );

  four_inputs_sweep #(.SETTLE(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .out(out_s[2]),
    .a(a[2]), .b(b[2]), .c(c[2]), .d(d[2]), .busy(busy[2]), .done(done[2]),
    .result(result[2]), .pass(pass[2]), .mismatch_cnt(mm[2]), .first_fail(ff[2])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] vec_of(input int i);
    return {a[i], b[i], c[i], d[i]};
  endfunction

  // Reference: what a full sweep over table t must report.
  function automatic int ref_mismatches(input logic [15:0] t);
    int n = 0;
    for (int k = 0; k < 16; k++) if (t[k] != GATE_EXPECT[k]) n++;
    return n;
  endfunction

  function automatic int ref_first_fail(input logic [15:0] t);
    for (int k = 0; k < 16; k++) if (t[k] != GATE_EXPECT[k]) return k;
    return 0;
  endfunction

  task automatic check_idle_clear(input int i, input string tag);
    chk({tag, ".busy"},   32'(busy[i]),   32'd0);
    chk({tag, ".done"},   32'(done[i]),   32'd0);
    chk({tag, ".vec"},    32'(vec_of(i)), 32'd0);
    chk({tag, ".result"}, 32'(result[i]), 32'd0);
    chk({tag, ".pass"},   32'(pass[i]),   32'd0);
    chk({tag, ".mm"},     32'(mm[i]),     32'd0);
    chk({tag, ".ff"},     32'(ff[i]),     32'd0);
  endtask

  // Entered at #1 after the edge that accepted start (E0); leaves at #1
  // after E0+16*S+1 (the first IDLE cycle).
  task automatic sweep_body(input int i, input string tag);
    int s = settle_of[i];
    logic [15:0] t = tbl[i];
    for (int j = 0; j < 16 * s; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      chk({tag, ".busy_run"}, 32'(busy[i]), 32'd1);
      chk({tag, ".done_run"}, 32'(done[i]), 32'd0);
      chk({tag, ".vec_hold"}, 32'(vec_of(i)), 32'(j / s));
    end
    @(posedge clk); #1;
    chk({tag, ".done"},   32'(done[i]),   32'd1);
    chk({tag, ".busy_d"}, 32'(busy[i]),   32'd0);
    chk({tag, ".result"}, 32'(result[i]), 32'(t));
    chk({tag, ".pass"},   32'(pass[i]),   32'(t == GATE_EXPECT));
    chk({tag, ".mm"},     32'(mm[i]),     32'(ref_mismatches(t)));
    chk({tag, ".ff"},     32'(ff[i]),     32'(ref_first_fail(t)));
    @(posedge clk); #1;
    chk({tag, ".done_off"}, 32'(done[i]),   32'd0);
    chk({tag, ".busy_off"}, 32'(busy[i]),   32'd0);
    chk({tag, ".res_hold"}, 32'(result[i]), 32'(t));
    chk({tag, ".mm_hold"},  32'(mm[i]),     32'(ref_mismatches(t)));
  endtask

  task automatic run_sweep(input int i, input logic [15:0] t, input string tag);
    @(negedge clk);
    tbl[i]   = t;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    sweep_body(i, tag);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      tbl[i]   = GATE_EXPECT;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_idle_clear(i, $sformatf("reset%0d", i));
    @(negedge clk);
    rst = 1'b0;

    run_sweep(0, GATE_EXPECT, "gate_s2");
    run_sweep(1, 16'hFFFF,    "tie1_s1");
    run_sweep(1, 16'h0000,    "tie0_s1");
    run_sweep(2, GATE_EXPECT, "gate_s3");

    for (int r = 0; r < 6; r++) begin
      int i = int'($urandom_range(2, 0));
      logic [15:0] t;
      if (r % 2 == 0) t = 16'($urandom);
      else            t = GATE_EXPECT ^ (16'h1 << $urandom_range(15, 0));
      run_sweep(i, t, $sformatf("rand%0d_i%0d", r, i));
    end

    // Start held high: ignored while running, restarts after the IDLE cycle.
    @(negedge clk);
    tbl[0]   = 16'h1234;
    start[0] = 1'b1;
    @(posedge clk); #1;
    sweep_body(0, "hold_a");
    tbl[0] = GATE_EXPECT;
    @(posedge clk); #1;
    chk("hold.restart_busy", 32'(busy[0]),   32'd1);
    chk("hold.restart_res",  32'(result[0]), 32'd0);
    chk("hold.restart_mm",   32'(mm[0]),     32'd0);
    chk("hold.restart_pass", 32'(pass[0]),   32'd0);
    sweep_body(0, "hold_b");
    start[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold.stays_idle", 32'(busy[0]), 32'd0);
    end

    // Reset while vector 7 is driven.
    @(negedge clk);
    tbl[0]   = 16'hFFFF;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("rst_mid.vec7", 32'(vec_of(0)), 32'd7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_clear(0, "rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.idle", 32'(busy[0]), 32'd0);
    run_sweep(0, GATE_EXPECT, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
